// File: rtl/seg7_pkg.sv
// Shared segment constants and BCD decode for the seg7 scan driver.
// Segment order {a,b,c,d,e,f,g}, bit 6 = a, active-low.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;

  // Non-BCD codes 10..15 render dark.
  function automatic logic [6:0] seg7_dec(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder.
// Ports: bcd_i (4-bit digit), seg_o ({a..g}, active-low).
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = seg7_dec(bcd_i);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit common-anode 7-segment scan driver.
// Ports: iClk, irst (async active-low), iBCD/iLoad (shadow capture),
//   iBlank (force dark), oSeg/oAn (active-low, registered), oIdx.
// Optional macro SEG7_LZB_EN enables leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic                  iClk,
  input  logic                  irst,
  input  logic [4*DIGITS-1:0]   iBCD,
  input  logic                  iLoad,
  input  logic                  iBlank,
  output logic [6:0]            oSeg,
  output logic [DIGITS-1:0]     oAn,
  output logic [2:0]            oIdx
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD    = CW'(DEAD_CYC);
  localparam logic [2:0]    IDX_MAX = 3'(DIGITS - 1);

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [2:0]          idx_q, idx_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [2:0]          oidx_q;

  logic [3:0]          dig;
  logic [6:0]          dig_seg;
  logic [DIGITS-1:0]   supp;
  logic                supp_cur;
  logic                lit;
`ifdef SEG7_LZB_EN
  logic                nz;
`endif

  // Digit select and leading-zero suppression mask.
  // Constant-index loops keep the mux free of wide variable selects.
  always_comb begin
    dig      = 4'd0;
    supp_cur = 1'b0;
    supp     = '0;
`ifdef SEG7_LZB_EN
    nz = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      nz      = nz | (shadow_q[4*k +: 4] != 4'd0);
      supp[k] = ~nz;
    end
`endif
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == 3'(k)) begin
        dig      = shadow_q[4*k +: 4];
        supp_cur = supp[k];
      end
    end
  end

  seg7_decode u_dec (
    .bcd_i (dig),
    .seg_o (dig_seg)
  );

  always_comb begin
    shadow_d = iLoad ? iBCD : shadow_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // Dead time at slot start keeps the previous anode from ghosting.
  always_comb begin
    lit  = ~iBlank & (cnt_q >= DEAD) & ~supp_cur;
    an_d = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (lit && idx_q == 3'(k)) an_d[k] = 1'b0;
    end
    seg_d = lit ? dig_seg : SEG_OFF;
  end

  always_ff @(posedge iClk or negedge irst) begin
    if (!irst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      seg_q    <= SEG_OFF;
      an_q     <= '1;
      oidx_q   <= 3'd0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      oidx_q   <= idx_q;
    end
  end

  assign oSeg = seg_q;
  assign oAn  = an_q;
  assign oIdx = oidx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver, DIGITS=4 SCAN_DIV=8 DEAD_CYC=2.
// Table of loaded values with hand-decoded segments, plus corner sequences.
module tb_seg7_scan_driver;

  logic        iClk = 1'b0;
  logic        irst = 1'b0;
  logic [15:0] iBCD = 16'h0;
  logic        iLoad = 1'b0;
  logic        iBlank = 1'b0;
  logic [6:0]  oSeg;
  logic [3:0]  oAn;
  logic [2:0]  oIdx;

  seg7_scan_driver #(
    .DIGITS   (4),
    .SCAN_DIV (8),
    .DEAD_CYC (2)
  ) dut (
    .iClk   (iClk),
    .irst   (irst),
    .iBCD   (iBCD),
    .iLoad  (iLoad),
    .iBlank (iBlank),
    .oSeg   (oSeg),
    .oAn    (oAn),
    .oIdx   (oIdx)
  );

  always #5 iClk = ~iClk;

  typedef struct packed {
    logic [15:0]      bcd;
    logic [3:0][6:0]  seg;
    logic [3:0]       lz;
  } vec_t;

  vec_t tbl [6];

  int checks = 0;
  int failures = 0;

  int m_cnt = 0;
  int m_idx = 0;
  int cur = 3;
  int pend = 3;
  int lit_cnt [4];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic supp(input int r, input int k);
`ifdef SEG7_LZB_EN
    return tbl[r].lz[k];
`else
    return 1'b0;
`endif
  endfunction

  // One clock: predict outputs from pre-edge model state, then compare.
  task automatic tick();
    logic       dark;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [2:0] e_idx;
    dark  = iBlank || (m_cnt < 2) || supp(cur, m_idx);
    e_an  = 4'hF;
    e_seg = 7'h7F;
    if (!dark) begin
      e_an[m_idx] = 1'b0;
      e_seg = tbl[cur].seg[m_idx];
    end
    e_idx = 3'(m_idx);
    @(posedge iClk);
    #1;
    if (iLoad) cur = pend;
    if (m_cnt == 7) begin
      m_cnt = 0;
      m_idx = (m_idx == 3) ? 0 : m_idx + 1;
    end else begin
      m_cnt++;
    end
    chk("seg", 32'(oSeg), 32'(e_seg));
    chk("an",  32'(oAn),  32'(e_an));
    chk("idx", 32'(oIdx), 32'(e_idx));
    for (int k = 0; k < 4; k++)
      if (oAn[k] == 1'b0) lit_cnt[k]++;
  endtask

  task automatic load(input int r);
    iBCD  = tbl[r].bcd;
    iLoad = 1'b1;
    pend  = r;
    tick();
    iLoad = 1'b0;
  endtask

  initial begin
    int sv_idx;
    tbl[0] = '{16'h1234,
      {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 4'b0000};
    tbl[1] = '{16'h00A7,
      {7'b0000001, 7'b0000001, 7'b1111111, 7'b0001111}, 4'b1100};
    tbl[2] = '{16'h0005,
      {7'b0000001, 7'b0000001, 7'b0000001, 7'b0100100}, 4'b1110};
    tbl[3] = '{16'h0000,
      {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001}, 4'b1110};
    tbl[4] = '{16'h9876,
      {7'b0000100, 7'b0000000, 7'b0001111, 7'b0100000}, 4'b0000};
    tbl[5] = '{16'h0F50,
      {7'b0000001, 7'b1111111, 7'b0100100, 7'b0000001}, 4'b1000};

    // Reset held while inputs toggle.
    for (int i = 0; i < 3; i++) begin
      iBCD   = 16'h1111 * 16'(i + 3);
      iLoad  = i[0];
      iBlank = ~i[0];
      @(posedge iClk);
      #1;
      chk("rst_seg", 32'(oSeg), 32'h7F);
      chk("rst_an",  32'(oAn),  32'hF);
      chk("rst_idx", 32'(oIdx), 32'h0);
    end
    iLoad  = 1'b0;
    iBlank = 1'b0;
    irst   = 1'b1;
    m_cnt = 0; m_idx = 0; cur = 3;
    tick();
    tick();
    tick();
    chk("first_lit_an",  32'(oAn),  32'hE);
    chk("first_lit_seg", 32'(oSeg), 32'h01);

    // Table: load each value, observe a full rotation.
    for (int r = 0; r < 6; r++) begin
      load(r);
      for (int k = 0; k < 4; k++) lit_cnt[k] = 0;
      for (int c = 0; c < 32; c++) tick();
      for (int k = 0; k < 4; k++)
        chk($sformatf("lit_cycles_r%0d_d%0d", r, k), 32'(lit_cnt[k]),
            supp(r, k) ? 32'd0 : 32'd6);
    end

    // Blank pulse of 3 cycles mid-slot.
    load(0);
    for (int i = 0; i < 40 && m_cnt != 3; i++) tick();
    sv_idx = m_idx;
    iBlank = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blank_an",  32'(oAn),  32'hF);
      chk("blank_seg", 32'(oSeg), 32'h7F);
    end
    iBlank = 1'b0;
    tick();
    chk("blank_idx_kept", 32'(oIdx), 32'(sv_idx));
    chk("relit", 32'(oAn == 4'hF), 32'h0);

    // Load coincident with slot wrap.
    for (int i = 0; i < 40 && m_cnt != 7; i++) tick();
    load(4);
    for (int c = 0; c < 16; c++) tick();

    // Async reset at cnt=4 of digit 2.
    load(0);
    for (int i = 0; i < 64 && !(m_idx == 2 && m_cnt == 4); i++) tick();
    chk("pre_rst_an", 32'(oAn), 32'hB);
    irst = 1'b0;
    #1;
    chk("async_rst_an",  32'(oAn),  32'hF);
    chk("async_rst_seg", 32'(oSeg), 32'h7F);
    chk("async_rst_idx", 32'(oIdx), 32'h0);
    @(posedge iClk);
    #1;
    irst = 1'b1;
    m_cnt = 0; m_idx = 0; cur = 3;
    tick();
    tick();
    tick();
    chk("restart_an",  32'(oAn),  32'hE);
    chk("restart_seg", 32'(oSeg), 32'h01);
    for (int c = 0; c < 32; c++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
